// File: rtl/segment_capture_ctrl_pkg.sv
// Shared types for the segment capture sequencer: FSM encoding, error bit
// positions and the per-state registered output set.
package segment_capture_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        ARMING    = 3'd1,
        WAIT_TRIG = 3'd2,
        CAPTURE   = 3'd3,
        HOLDOFF   = 3'd4,
        DONE      = 3'd5
    } state_t;

    localparam int ERR_GO_OVERRUN   = 0;
    localparam int ERR_PERIOD_SHORT = 1;
    localparam int ERR_FIFO_OVF     = 2;

    typedef struct packed {
        logic arm;
        logic armed_ready;
        logic done;
        logic wr;
        logic busy;
    } ctrl_outs_t;

    // Output pattern registered alongside each state transition.
    function automatic ctrl_outs_t state_outs(state_t s);
        ctrl_outs_t o;
        o = '0;
        case (s)
            ARMING:             begin o.arm = 1'b1; o.busy = 1'b1; end
            WAIT_TRIG, HOLDOFF: begin o.arm = 1'b1; o.armed_ready = 1'b1; o.busy = 1'b1; end
            CAPTURE:            begin o.arm = 1'b1; o.armed_ready = 1'b1; o.wr = 1'b1; o.busy = 1'b1; end
            DONE:               o.done = 1'b1;
            default:            o = '0;
        endcase
        return o;
    endfunction

endpackage

// File: rtl/segment_capture_ctrl_seg_period_counter.sv
// Saturating up-counter with synchronous clear and a terminal-count flag,
// used for both the in-segment sample count and the segment period count.
module seg_period_counter #(
    parameter int W = 20
) (
    input  logic         adc_clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         en,
    input  logic [W-1:0] term,
    output logic [W-1:0] cnt,
    output logic         tc
);

    always_ff @(posedge adc_clk) begin
        if (reset || clr)
            cnt <= '0;
        else if (en && cnt != '1)
            cnt <= cnt + W'(1);
    end

    assign tc = (cnt == term);

endmodule

// File: rtl/segment_capture_ctrl.sv
// Multi-segment ADC capture sequencer: arms the trigger unit, starts segments on
// capture_go (or a fixed period in timed mode) and gates FIFO writes.
module segment_capture_ctrl
    import segment_capture_ctrl_pkg::*;
#(
    parameter int SEG_W  = 16,
    parameter int SAMP_W = 20
) (
    input  logic              adc_clk,
    input  logic              reset,
    input  logic              start_i,
    input  logic              timed_mode_i,
    input  logic [SEG_W-1:0]  num_seg_i,
    input  logic [SAMP_W-1:0] seg_samples_i,
    input  logic [SAMP_W-1:0] seg_period_i,
    input  logic              fifo_ready_i,
    input  logic              fifo_full_i,
    input  logic              capture_go_i,
    output logic              arm_o,
    output logic              armed_ready_o,
    output logic              capture_done_o,
    output logic              fifo_wr_o,
    output logic [SEG_W-1:0]  seg_cnt_o,
    output logic              busy_o,
    output logic [2:0]        err_o
);

    state_t            state;
    ctrl_outs_t        outs;
    logic              start_d;
    logic              timed_q, short_q;
    logic [SEG_W-1:0]  num_seg_q;
    logic [SAMP_W-1:0] samp_term_q, period_term_q;
    logic [SAMP_W-1:0] samp_cnt, period_cnt;
    logic [SAMP_W-1:0] samp_eff;
    logic              samp_tc, period_tc;
    logic              in_cap, in_hold, start_rise, seg_last, back_to_back;

    assign in_cap       = (state == CAPTURE);
    assign in_hold      = (state == HOLDOFF);
    assign start_rise   = start_i & ~start_d;
    assign seg_last     = ((seg_cnt_o + SEG_W'(1)) == num_seg_q);
    assign back_to_back = in_cap && samp_tc && !seg_last && timed_q && short_q;
    assign samp_eff     = (seg_samples_i == '0) ? SAMP_W'(1) : seg_samples_i;

    seg_period_counter #(.W(SAMP_W)) u_samp_cnt (
        .adc_clk (adc_clk),
        .reset   (reset),
        .clr     (!in_cap || samp_tc),
        .en      (in_cap),
        .term    (samp_term_q),
        .cnt     (samp_cnt),
        .tc      (samp_tc)
    );

    // Period runs from each segment's first write through CAPTURE and HOLDOFF.
    seg_period_counter #(.W(SAMP_W)) u_period_cnt (
        .adc_clk (adc_clk),
        .reset   (reset),
        .clr     (!(in_cap || in_hold) || (in_hold && period_tc) || back_to_back),
        .en      (in_cap || in_hold),
        .term    (period_term_q),
        .cnt     (period_cnt),
        .tc      (period_tc)
    );

    always_ff @(posedge adc_clk) begin
        if (reset) begin
            state         <= IDLE;
            outs          <= '0;
            start_d       <= 1'b0;
            timed_q       <= 1'b0;
            short_q       <= 1'b0;
            num_seg_q     <= '0;
            samp_term_q   <= '0;
            period_term_q <= '0;
            seg_cnt_o     <= '0;
            err_o         <= '0;
        end else begin
            start_d <= start_i;
            if (outs.busy && !start_i) begin
                state <= IDLE;
                outs  <= state_outs(IDLE);
            end else begin
                case (state)
                    IDLE: if (start_rise) begin
                        timed_q       <= timed_mode_i;
                        num_seg_q     <= (num_seg_i == '0) ? SEG_W'(1) : num_seg_i;
                        samp_term_q   <= samp_eff - SAMP_W'(1);
                        period_term_q <= seg_period_i - SAMP_W'(1);
                        short_q       <= (seg_period_i <= samp_eff);
                        seg_cnt_o     <= '0;
                        err_o         <= '0;
                        state         <= ARMING;
                        outs          <= state_outs(ARMING);
                    end
                    ARMING: if (fifo_ready_i) begin
                        state <= WAIT_TRIG;
                        outs  <= state_outs(WAIT_TRIG);
                    end
                    WAIT_TRIG: if (capture_go_i) begin
                        state <= CAPTURE;
                        outs  <= state_outs(CAPTURE);
                    end
                    CAPTURE: begin
                        if (capture_go_i)
                            err_o[ERR_GO_OVERRUN] <= 1'b1;
                        if (fifo_full_i) begin
                            err_o[ERR_FIFO_OVF] <= 1'b1;
                            state <= DONE;
                            outs  <= state_outs(DONE);
                        end else if (samp_tc) begin
                            if (seg_cnt_o != num_seg_q)
                                seg_cnt_o <= seg_cnt_o + SEG_W'(1);
                            if (seg_last) begin
                                state <= DONE;
                                outs  <= state_outs(DONE);
                            end else if (!timed_q) begin
                                state <= WAIT_TRIG;
                                outs  <= state_outs(WAIT_TRIG);
                            end else if (short_q) begin
                                // Period too short: next segment follows with no gap.
                                err_o[ERR_PERIOD_SHORT] <= 1'b1;
                            end else begin
                                state <= HOLDOFF;
                                outs  <= state_outs(HOLDOFF);
                            end
                        end
                    end
                    HOLDOFF: begin
                        if (capture_go_i)
                            err_o[ERR_GO_OVERRUN] <= 1'b1;
                        if (period_tc) begin
                            state <= CAPTURE;
                            outs  <= state_outs(CAPTURE);
                        end
                    end
                    DONE: if (!start_i) begin
                        state <= IDLE;
                        outs  <= state_outs(IDLE);
                    end
                    default: begin
                        state <= IDLE;
                        outs  <= state_outs(IDLE);
                    end
                endcase
            end
        end
    end

    assign arm_o          = outs.arm;
    assign armed_ready_o  = outs.armed_ready;
    assign capture_done_o = outs.done;
    assign busy_o         = outs.busy;
    assign fifo_wr_o      = outs.wr & ~fifo_full_i;

endmodule

// File: tb/tb_segment_capture_ctrl.sv
// Directed and randomized runs of segment_capture_ctrl checked cycle by cycle
// against a segment-level model of expected write bursts, done and error flags.
module tb_segment_capture_ctrl;

    localparam int SEG_W   = 16;
    localparam int SAMP_W  = 20;
    localparam int LEN_MAX = 96;

    logic              adc_clk = 1'b0;
    logic              reset;
    logic              start_i, timed_mode_i, fifo_ready_i, fifo_full_i, capture_go_i;
    logic [SEG_W-1:0]  num_seg_i;
    logic [SAMP_W-1:0] seg_samples_i, seg_period_i;
    logic              arm_o, armed_ready_o, capture_done_o, fifo_wr_o, busy_o;
    logic [SEG_W-1:0]  seg_cnt_o;
    logic [2:0]        err_o;

    int checks = 0;
    int errors = 0;

    bit       go_v   [LEN_MAX];
    bit       full_v [LEN_MAX];
    bit       exp_wr [LEN_MAX];
    bit       exp_done [LEN_MAX];
    bit       exp_busy [LEN_MAX];
    int       exp_seg;
    bit [2:0] exp_err;

    segment_capture_ctrl #(.SEG_W(SEG_W), .SAMP_W(SAMP_W)) dut (
        .adc_clk        (adc_clk),
        .reset          (reset),
        .start_i        (start_i),
        .timed_mode_i   (timed_mode_i),
        .num_seg_i      (num_seg_i),
        .seg_samples_i  (seg_samples_i),
        .seg_period_i   (seg_period_i),
        .fifo_ready_i   (fifo_ready_i),
        .fifo_full_i    (fifo_full_i),
        .capture_go_i   (capture_go_i),
        .arm_o          (arm_o),
        .armed_ready_o  (armed_ready_o),
        .capture_done_o (capture_done_o),
        .fifo_wr_o      (fifo_wr_o),
        .seg_cnt_o      (seg_cnt_o),
        .busy_o         (busy_o),
        .err_o          (err_o)
    );

    always #5 adc_clk = ~adc_clk;

    task automatic chk(input string tag, input int c, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s cyc=%0d got=%0h exp=%0h", tag, c, obs, exp);
        end
    endtask

    task automatic clear_stim();
        for (int k = 0; k < LEN_MAX; k++) begin
            go_v[k]   = 1'b0;
            full_v[k] = 1'b0;
        end
    endtask

    // Segment-level model. Run starts (start rise) in cycle 0; first go can be
    // accepted in cycle 2. Events in cycle c take effect only when c < lim
    // (start dropped at stop_at, or end of observation window).
    task automatic model(input bit timed, input int nseg, input int nsamp, input int per,
                         input int len, input int stop_at);
        int ns, n, sp, lim, c, b, s, seg, end_c, last, lb;
        bit fin;
        ns    = (nseg == 0) ? 1 : nseg;
        n     = (nsamp == 0) ? 1 : nsamp;
        sp    = (per <= n) ? n : per;
        lim   = (stop_at < len - 1) ? stop_at : len - 1;
        c     = 2;
        b     = 0;
        seg   = 0;
        end_c = -1;
        fin   = 1'b0;
        exp_err = '0;
        for (int k = 0; k < LEN_MAX; k++) begin
            exp_wr[k] = 1'b0; exp_done[k] = 1'b0; exp_busy[k] = 1'b0;
        end
        while (!fin) begin
            if (seg == 0 || !timed) begin
                s = -1;
                for (int k = c; k < lim; k++)
                    if (go_v[k]) begin s = k; break; end
                if (s < 0) break;
                b = s + 1;
            end else begin
                b = b + sp;
                if (per <= n) exp_err[1] = 1'b1;
            end
            for (int i = 0; i < n; i++) begin
                int k;
                k = b + i;
                if (k > lim) begin fin = 1'b1; break; end
                if (go_v[k] && k < lim) exp_err[0] = 1'b1;
                if (full_v[k]) begin
                    if (k < lim) begin exp_err[2] = 1'b1; end_c = k; end
                    fin = 1'b1;
                    break;
                end
                exp_wr[k] = 1'b1;
            end
            if (fin) break;
            last = b + n - 1;
            if (last >= lim) break;
            seg++;
            if (seg == ns) begin end_c = last; break; end
            if (timed)
                for (int k = b + n; k < b + sp && k < lim; k++)
                    if (go_v[k]) exp_err[0] = 1'b1;
            c = b + n;
        end
        exp_seg = seg;
        if (end_c >= 0) lb = end_c;
        else lb = lim;
        for (int k = 1; k <= lb && k < len; k++) exp_busy[k] = 1'b1;
        if (end_c >= 0)
            for (int k = end_c + 1; k < len && k <= stop_at; k++) exp_done[k] = 1'b1;
    endtask

    task automatic run_scn(input string tag, input bit timed, input int nseg, input int nsamp,
                           input int per, input int len, input int stop_at);
        model(timed, nseg, nsamp, per, len, stop_at);
        for (int c = 0; c < len; c++) begin
            start_i      = (c < stop_at);
            capture_go_i = go_v[c];
            fifo_full_i  = full_v[c];
            if (c == 0) begin
                timed_mode_i  = timed;
                num_seg_i     = SEG_W'(nseg);
                seg_samples_i = SAMP_W'(nsamp);
                seg_period_i  = SAMP_W'(per);
            end else if (c == 1) begin
                // Inputs move after the start edge; the run must keep its latched copy.
                timed_mode_i  = ~timed;
                num_seg_i     = SEG_W'($urandom);
                seg_samples_i = SAMP_W'($urandom);
                seg_period_i  = SAMP_W'($urandom);
            end
            #1;
            chk({tag, ".wr"},   c, 32'(fifo_wr_o),      32'(exp_wr[c]));
            chk({tag, ".done"}, c, 32'(capture_done_o), 32'(exp_done[c]));
            chk({tag, ".busy"}, c, 32'(busy_o),         32'(exp_busy[c]));
            if (c == 1) begin
                chk({tag, ".arm1"},  c, 32'(arm_o),         32'd1);
                chk({tag, ".ardy1"}, c, 32'(armed_ready_o), 32'd0);
            end
            if (c == 2) chk({tag, ".ardy2"}, c, 32'(armed_ready_o), 32'd1);
            if (c == len - 1) begin
                chk({tag, ".seg"}, c, 32'(seg_cnt_o), 32'(exp_seg));
                chk({tag, ".err"}, c, 32'(err_o),     32'(exp_err));
                if (!exp_busy[c]) chk({tag, ".arm_end"}, c, 32'(arm_o), 32'd0);
            end
            @(posedge adc_clk);
            #1;
        end
        start_i      = 1'b0;
        capture_go_i = 1'b0;
        fifo_full_i  = 1'b0;
        repeat (2) @(posedge adc_clk);
        #1;
        chk({tag, ".td_done"}, len + 1, 32'(capture_done_o), 32'd0);
        chk({tag, ".td_busy"}, len + 1, 32'(busy_o),         32'd0);
        chk({tag, ".td_arm"},  len + 1, 32'(arm_o),          32'd0);
        chk({tag, ".td_seg"},  len + 1, 32'(seg_cnt_o),      32'(exp_seg));
    endtask

    initial begin
        reset         = 1'b1;
        start_i       = 1'b0;
        timed_mode_i  = 1'b0;
        num_seg_i     = '0;
        seg_samples_i = '0;
        seg_period_i  = '0;
        fifo_ready_i  = 1'b1;
        fifo_full_i   = 1'b0;
        capture_go_i  = 1'b0;
        repeat (3) @(posedge adc_clk);
        #1;
        reset = 1'b0;
        @(posedge adc_clk);
        #1;
        chk("rst.arm",  0, 32'(arm_o),          32'd0);
        chk("rst.ardy", 0, 32'(armed_ready_o),  32'd0);
        chk("rst.done", 0, 32'(capture_done_o), 32'd0);
        chk("rst.wr",   0, 32'(fifo_wr_o),      32'd0);
        chk("rst.seg",  0, 32'(seg_cnt_o),      32'd0);
        chk("rst.busy", 0, 32'(busy_o),         32'd0);
        chk("rst.err",  0, 32'(err_o),          32'd0);

        // Trigger mode, 3 segments of 4, gos 10 cycles apart.
        clear_stim(); go_v[3] = 1; go_v[13] = 1; go_v[23] = 1;
        run_scn("trig3x4", 1'b0, 3, 4, 0, 32, LEN_MAX);

        // Timed mode, 4 segments of 5, period 8.
        clear_stim(); go_v[3] = 1;
        run_scn("timed4x5p8", 1'b1, 4, 5, 8, 40, LEN_MAX);

        // Timed mode, period shorter than segment: back-to-back.
        clear_stim(); go_v[3] = 1;
        run_scn("timed_short", 1'b1, 2, 5, 3, 20, LEN_MAX);

        // Go arriving at sample 3 of an 8-sample segment.
        clear_stim(); go_v[3] = 1; go_v[7] = 1;
        run_scn("go_overrun", 1'b0, 2, 8, 0, 20, LEN_MAX);

        // FIFO full on sample 2 of the first segment.
        clear_stim(); go_v[3] = 1; full_v[6] = 1;
        run_scn("fifo_full", 1'b0, 2, 4, 0, 14, LEN_MAX);

        // Abort in WAIT_TRIG after one segment, then zero-config restart.
        clear_stim(); go_v[3] = 1;
        run_scn("abort", 1'b0, 3, 2, 0, 12, 8);
        clear_stim(); go_v[3] = 1;
        run_scn("zero_cfg", 1'b0, 0, 0, 0, 10, LEN_MAX);

        // Randomized runs.
        for (int r = 0; r < 24; r++) begin
            bit tm;
            int ns, nsm, per;
            tm  = 1'($urandom_range(0, 1));
            ns  = int'($urandom_range(0, 4));
            nsm = int'($urandom_range(0, 6));
            per = int'($urandom_range(0, 12));
            clear_stim();
            for (int k = 0; k < 80; k++) begin
                go_v[k]   = ($urandom_range(0, 5) == 0);
                full_v[k] = ($urandom_range(0, 99) == 0);
            end
            run_scn($sformatf("rnd%0d", r), tm, ns, nsm, per, 80, LEN_MAX);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
